// File: rtl/gpu_sync_fifo.sv
// gpu_sync_fifo: single-clock FIFO with a registered or first-word-fall-through read port,
// a registered occupancy count, threshold flags and sticky overflow/underflow flags.
//
// Parameters
//   DATA_WIDTH  entry width (values below 1 behave as 1)
//   DEPTH_WIDTH log2 of capacity (values below 1 behave as 1)
//   FWFT        0: rd_data_o registered one cycle after an accepted read
//               1: head entry presented combinationally, rd_en_i pops it
//   AF_LEVEL    almost_full_o when level_o >= AF_LEVEL
//   AE_LEVEL    almost_empty_o when level_o <= AE_LEVEL
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wr_data_i, wr_en_i       write data and request
//   rd_en_i                  read request (FWFT: acknowledge of head)
//   clr_err_i                clears the sticky error flags
//   rd_data_o, rd_valid_o    read data and its qualifier
//   full_o, empty_o          level == capacity / level == 0
//   almost_full_o/empty_o    threshold flags
//   level_o                  entry count, 0..capacity
//   overflow_o, underflow_o  sticky error flags
module gpu_sync_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 4,
  parameter int FWFT        = 0,
  parameter int AF_LEVEL    = (1 << DEPTH_WIDTH) - 1,
  parameter int AE_LEVEL    = 1,
  localparam int DW = (DATA_WIDTH < 1) ? 1 : DATA_WIDTH,
  localparam int AW = (DEPTH_WIDTH < 1) ? 1 : DEPTH_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  input  logic          clr_err_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int Depth = 1 << AW;

  // Out-of-range thresholds leave the flags meaningless; flag them at elaboration.
  if (AF_LEVEL > Depth || AE_LEVEL < 0) begin : g_bad_level
    $warning("gpu_sync_fifo: AF_LEVEL/AE_LEVEL out of range, threshold flags undefined");
  end

  logic [DW-1:0] mem [Depth];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q,  level_d;
  logic        overflow_q,  overflow_d;
  logic        underflow_q, underflow_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  // Pointers carry one extra wrap bit: equal low bits with differing MSBs means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_acc = rd_en_i && !empty;
  assign wr_acc = wr_en_i && (!full || rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // Error events take precedence over a simultaneous clear.
    if (clr_err_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en_i && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en_i && !rd_acc) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; the reset pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data_o  = mem[rd_ptr_q[AW-1:0]];
    assign rd_valid_o = !empty;
  end else begin : g_reg
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;

    // A read of the slot being written this edge sees the older entry (NBA ordering).
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign level_o        = level_q;
  assign almost_full_o  = int'(level_q) >= AF_LEVEL;
  assign almost_empty_o = int'(level_q) <= AE_LEVEL;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_gpu_sync_fifo.sv
// tb_gpu_sync_fifo: drives a registered-read instance and a FWFT instance (capacity 4, 8-bit)
// with the same directed stimulus. A queue model predicts every output each cycle and literal
// checks pin the model at the interesting points.
module tb_gpu_sync_fifo;

  localparam int Cap  = 4;
  localparam int Af0  = 3;
  localparam int Ae0  = 1;
  localparam int Af1  = 2;
  localparam int Ae1  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1;
  logic       full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1;
  logic [2:0] level0, level1;
  logic       ovf0, ovf1, unf0, unf1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpu_sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH_WIDTH(2),
    .FWFT       (0),
    .AF_LEVEL   (Af0),
    .AE_LEVEL   (Ae0)
  ) dut0 (
    .clk           (clk),
    .rst           (rst),
    .wr_data_i     (wr_data),
    .wr_en_i       (wr_en),
    .rd_en_i       (rd_en),
    .clr_err_i     (clr),
    .rd_data_o     (rd_data0),
    .rd_valid_o    (rd_valid0),
    .full_o        (full0),
    .empty_o       (empty0),
    .almost_full_o (af0),
    .almost_empty_o(ae0),
    .level_o       (level0),
    .overflow_o    (ovf0),
    .underflow_o   (unf0)
  );

  gpu_sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH_WIDTH(2),
    .FWFT       (1),
    .AF_LEVEL   (Af1),
    .AE_LEVEL   (Ae1)
  ) dut1 (
    .clk           (clk),
    .rst           (rst),
    .wr_data_i     (wr_data),
    .wr_en_i       (wr_en),
    .rd_en_i       (rd_en),
    .clr_err_i     (clr),
    .rd_data_o     (rd_data1),
    .rd_valid_o    (rd_valid1),
    .full_o        (full1),
    .empty_o       (empty1),
    .almost_full_o (af1),
    .almost_empty_o(ae1),
    .level_o       (level1),
    .overflow_o    (ovf1),
    .underflow_o   (unf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO is a queue of at most Cap entries.
  logic [7:0] q[$];
  bit         m_ready = 1'b0;
  bit         m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  always @(posedge clk) begin
    bit racc, wacc;
    if (rst) begin
      q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_rv    = 1'b0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      racc = rd_en && (q.size() != 0);
      wacc = wr_en && (q.size() < Cap || racc);
      if (racc) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (wacc) q.push_back(wr_data);
      if (wr_en && !wacc) m_ovf = 1'b1;
      else if (clr)       m_ovf = 1'b0;
      if (rd_en && !racc) m_unf = 1'b1;
      else if (clr)       m_unf = 1'b0;
    end
  end

  always @(negedge clk) begin
    int lvl;
    if (m_ready) begin
      lvl = q.size();
      chk("level0", 32'(level0), 32'(lvl));
      chk("level1", 32'(level1), 32'(lvl));
      chk("full0", 32'(full0), 32'(lvl == Cap));
      chk("full1", 32'(full1), 32'(lvl == Cap));
      chk("empty0", 32'(empty0), 32'(lvl == 0));
      chk("empty1", 32'(empty1), 32'(lvl == 0));
      chk("af0", 32'(af0), 32'(lvl >= Af0));
      chk("ae0", 32'(ae0), 32'(lvl <= Ae0));
      chk("af1", 32'(af1), 32'(lvl >= Af1));
      chk("ae1", 32'(ae1), 32'(lvl <= Ae1));
      chk("ovf0", 32'(ovf0), 32'(m_ovf));
      chk("ovf1", 32'(ovf1), 32'(m_ovf));
      chk("unf0", 32'(unf0), 32'(m_unf));
      chk("unf1", 32'(unf1), 32'(m_unf));
      chk("rv0", 32'(rd_valid0), 32'(m_rv));
      if (m_rv) chk("rd0", 32'(rd_data0), 32'(m_rd));
      chk("rv1", 32'(rd_valid1), 32'(lvl != 0));
      if (lvl != 0) chk("rd1", 32'(rd_data1), 32'(q[0]));
    end
  end

  task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rd,
                      input bit c);
    rst     = r;
    wr_en   = w;
    wr_data = d;
    rd_en   = rd;
    clr     = c;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, 32'(level0), 0);
    chk({tag, "_empty"}, 32'(empty0), 1);
    chk({tag, "_full"}, 32'(full0), 0);
    chk({tag, "_ae"}, 32'(ae0), 1);
    chk({tag, "_af"}, 32'(af0), 0);
    chk({tag, "_ovf"}, 32'(ovf0), 0);
    chk({tag, "_unf"}, 32'(unf0), 0);
    chk({tag, "_rv0"}, 32'(rd_valid0), 0);
    chk({tag, "_rv1"}, 32'(rd_valid1), 0);
  endtask

  logic [7:0] exp38 [8];
  logic [7:0] fill_a [4];

  initial begin
    fill_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    exp38  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h66, 8'h66, 8'h66, 8'h66};

    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    chk_reset_state("rst");

    // Fill, overflow, clear, drain.
    step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    step(0, 1, 8'h33, 0, 0);
    step(0, 1, 8'h44, 0, 0);
    chk("fill_full", 32'(full0), 1);
    chk("fill_level", 32'(level0), 4);
    chk("fwft_head", 32'(rd_data1), 32'h11);
    step(0, 1, 8'h55, 0, 0);
    chk("ovf_set", 32'(ovf0), 1);
    chk("ovf_level", 32'(level0), 4);
    step(0, 0, 8'h00, 0, 1);
    chk("ovf_clr", 32'(ovf0), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk("drain_rv", 32'(rd_valid0), 1);
      chk("drain_data", 32'(rd_data0), 32'(8'h11 * (i + 1)));
    end
    chk("drain_empty", 32'(empty0), 1);
    step(0, 0, 8'h00, 0, 0);
    chk("idle_rv", 32'(rd_valid0), 0);

    // Empty with simultaneous write and read: read rejected.
    step(0, 1, 8'h77, 1, 0);
    chk("ew_unf", 32'(unf0), 1);
    chk("ew_level", 32'(level0), 1);
    chk("ew_fwft", 32'(rd_data1), 32'h77);
    step(0, 0, 8'h00, 1, 0);
    chk("ew_read", 32'(rd_data0), 32'h77);
    step(0, 0, 8'h00, 1, 1);
    chk("unf_set_wins", 32'(unf0), 1);
    step(0, 0, 8'h00, 0, 1);
    chk("unf_clr", 32'(unf0), 0);

    // Full with simultaneous read and write for 8 cycles.
    for (int i = 0; i < 4; i++) step(0, 1, fill_a[i], 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'h66, 1, 0);
      chk("rw_data", 32'(rd_data0), 32'(exp38[i]));
      chk("rw_full", 32'(full0), 1);
      chk("rw_level", 32'(level0), 4);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk("rw_tail", 32'(rd_data0), 32'h66);
    end
    chk("rw_ovf", 32'(ovf0), 0);

    // FWFT fall-through without a read, then pop.
    step(0, 1, 8'hA5, 0, 0);
    chk("fwft_rv", 32'(rd_valid1), 1);
    chk("fwft_data", 32'(rd_data1), 32'hA5);
    chk("fwft_rv0", 32'(rd_valid0), 0);
    step(0, 0, 8'h00, 0, 0);
    chk("fwft_hold", 32'(rd_data1), 32'hA5);
    step(0, 0, 8'h00, 1, 0);
    chk("fwft_pop_empty", 32'(empty1), 1);
    chk("fwft_pop_rv", 32'(rd_valid1), 0);
    chk("reg_pop_data", 32'(rd_data0), 32'hA5);

    // Threshold flags over a fill, overflow, partial drain, then reset mid-operation.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'hC0 + 8'(i), 0, 0);
      chk("thr_af", 32'(af0), 32'(i >= 2));
      chk("thr_ae", 32'(ae0), 32'(i == 0));
    end
    step(0, 1, 8'hCF, 0, 0);
    chk("thr_ovf", 32'(ovf0), 1);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("thr_level2", 32'(level0), 2);
    chk("thr_af2", 32'(af0), 0);
    chk("thr_ae2", 32'(ae0), 0);
    step(1, 1, 8'hEE, 1, 0);
    chk_reset_state("mid_rst");

    // Retry pass after reset.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'hD0 + 8'(i), 0, 0);
      if (i == 0) chk("retry_head", 32'(rd_data1), 32'hD0);
    end
    chk("retry_full", 32'(full0), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1, 0);
      chk("retry_data", 32'(rd_data0), 32'(8'hD0 + 8'(i)));
      chk("retry_ae", 32'(ae0), 32'(i >= 2));
    end
    chk("retry_empty", 32'(empty0), 1);
    step(0, 0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_sync_fifo.md
GPU_SYNC_FIFO -- requirements
Module: gpu_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 16: entry width in bits; values below 1 SHALL be treated as 1.
REQ-002 Parameter DEPTH_WIDTH, default 4: log2 of capacity, so capacity = 2^DEPTH_WIDTH; values below 1 SHALL be treated as 1 (AW below = effective DEPTH_WIDTH).
REQ-003 Parameter FWFT, default 0: 0 = registered read mode; 1 = first-word-fall-through mode.
REQ-004 Parameter AF_LEVEL, default 2^DEPTH_WIDTH-1: almost_full threshold.
REQ-005 Parameter AE_LEVEL, default 1: almost_empty threshold.
REQ-006 clk  in  1  clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wr_data_i  in  DATA_WIDTH  write data.
REQ-009 wr_en_i  in  1  write request.
REQ-010 rd_en_i  in  1  read request (FWFT: pop/acknowledge of head).
REQ-011 clr_err_i  in  1  clears sticky error flags.
REQ-012 rd_data_o  out  DATA_WIDTH  read data.
REQ-013 rd_valid_o  out  1  rd_data_o holds a valid entry.
REQ-014 full_o, empty_o  out  1 each  level == capacity / level == 0.
REQ-015 almost_full_o, almost_empty_o  out  1 each  level >= AF_LEVEL / level <= AE_LEVEL.
REQ-016 level_o  out  AW+1  current entry count, 0..2^AW.
REQ-017 overflow_o, underflow_o  out  1 each  sticky error flags.

Function
REQ-018 Storage: 2^AW x DATA_WIDTH array; write/read pointers AW+1 bits wide, wrapping modulo 2^(AW+1); full/empty derived from pointer MSB plus low-bit equality.
REQ-019 Write accepted (wr_acc) when wr_en_i and (!full_o or rd_acc); wr_data_i stored at wr_ptr, wr_ptr += 1.
REQ-020 Read accepted (rd_acc) when rd_en_i and !empty_o; rd_ptr += 1.
REQ-021 Full with wr_en_i and rd_en_i in the same cycle: both accepted, level unchanged.
REQ-022 Empty with wr_en_i and rd_en_i in the same cycle: write accepted, read rejected, level becomes 1.
REQ-023 level_o += 1 on wr_acc only, -= 1 on rd_acc only, unchanged on both or neither; registered, valid the cycle after the edge.
REQ-024 wr_en_i while full without rd_acc: data dropped, no state change except overflow_o <= 1.
REQ-025 rd_en_i while empty: no pointer change, underflow_o <= 1.
REQ-026 overflow_o/underflow_o remain set until clr_err_i or rst; an error event in the same cycle as clr_err_i SHALL leave the flag set (set wins).
REQ-027 FWFT=0: on rd_acc, rd_data_o <= mem[rd_ptr] and rd_valid_o <= 1 at the next edge (latency 1); without rd_acc, rd_valid_o <= 0 and rd_data_o holds its last value.
REQ-028 FWFT=0: a read accepted in the cycle an entry is written to the same address SHALL return the previously stored (older) entry; no write-to-read bypass is needed because REQ-022 forbids reading an empty slot.
REQ-029 FWFT=1: rd_data_o = mem[rd_ptr] combinationally and rd_valid_o = !empty_o; a word written at edge N appears on rd_data_o after edge N (zero added latency).
REQ-030 almost_full_o, almost_empty_o, full_o and empty_o SHALL be combinational from registered state and consistent with level_o in every cycle.
REQ-031 Behaviour for AF_LEVEL > 2^AW or AE_LEVEL < 0 is undefined; the simulation model SHALL print a warning at elaboration for such values.

Reset
REQ-032 rst SHALL have priority over all other inputs, including a write or read in the same cycle.
REQ-033 After rst: both pointers = 0, level_o = 0, empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = (AF_LEVEL == 0), overflow_o = 0, underflow_o = 0, rd_valid_o = 0.
REQ-034 Array contents SHALL not be reset; rd_data_o after reset is don't-care while rd_valid_o = 0.
REQ-035 Reset mid-operation SHALL discard all stored entries; the first write after reset lands at address 0.

Verification
REQ-036 DW=8, DEPTH_WIDTH=2, FWFT=0: write 0x11..0x44 on 4 cycles -> full_o=1, level_o=4; 4 reads -> rd_data_o 0x11,0x22,0x33,0x44, each one cycle after its read with rd_valid_o=1; then empty_o=1.
REQ-037 Full FIFO, write 0x55 without read -> overflow_o=1, level_o stays 4, data read back unchanged; clr_err_i pulse -> overflow_o=0.
REQ-038 Full FIFO, simultaneous read and write of 0x66 for 8 cycles -> level_o stays 4, full_o stays 1, output order preserved with 0x66 entries last.
REQ-039 Empty FIFO, simultaneous wr 0x77 and rd -> underflow_o=1, level_o=1, next read returns 0x77.
REQ-040 FWFT=1: write 0xA5 at edge N -> rd_valid_o=1 and rd_data_o=0xA5 in cycle N+1 without a read; rd_en_i pops it and empty_o=1.
REQ-041 AF_LEVEL=3, AE_LEVEL=1; fill 0->4 then drain, with rst asserted at level 2 on a retry pass -> flags track REQ-015, and the post-reset state matches REQ-033.
